// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param: run-time configurable Moore serial pattern detector with saturating match counter
module seq_detector_moore_param #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               x,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_cnt
);
   logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_n, mask;
   logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_n, len_c;
   logic               ovl_q, ovl_d, y_q, y_d, hit;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q  <= '0;
         len_q  <= LEN_W'(MAX_LEN);
         ovl_q  <= 1'b1;
         hist_q <= '0;
         fill_q <= '0;
         y_q    <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         y_q    <= y_d;
         cnt_q  <= cnt_d;
      end
   end
   always_comb begin
      hist_n = {hist_q[MAX_LEN-2:0], x};
      fill_n = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
      mask   = ~({MAX_LEN{1'b1}} << len_q);
      hit    = en && !cfg_load && (fill_n == len_q) && (((hist_n ^ pat_q) & mask) == '0);
      len_c  = (cfg_len == '0) ? LEN_W'(1) : (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      pat_d  = cfg_load ? cfg_pattern : pat_q;
      len_d  = cfg_load ? len_c : len_q;
      ovl_d  = cfg_load ? cfg_overlap : ovl_q;
      hist_d = cfg_load ? '0 : en ? hist_n : hist_q;
      // non-overlapping mode restarts the fill so the next match needs len fresh bits
      fill_d = cfg_load ? '0 : !en ? fill_q : (hit && !ovl_q) ? '0 : fill_n;
      y_d    = hit;
      cnt_d  = cnt_clr ? CNT_W'(hit) : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   assign y         = y_q;
   assign match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detector_moore_param.sv
// tb_seq_detector_moore_param: directed stimulus checked against a bit-queue reference model
module tb_seq_detector_moore_param;
   logic       clk = 0, reset = 1, en = 0, x = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
   logic [7:0] cfg_pattern = 0;
   logic [3:0] cfg_len = 0;
   logic       y8, y2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int         n_chk = 0, n_fail = 0;
   bit         run = 0;
   bit         q[$];
   logic [7:0] m_pat;
   int         m_len, ec8, ec2;
   bit         m_ovl, ey, hit;

   always #5 clk = ~clk;

   seq_detector_moore_param #(.MAX_LEN(8), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .y(y8), .match_cnt(cnt8));
   seq_detector_moore_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .y(y2), .match_cnt(cnt2));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference: the bits seen since the last clear, newest at the back
   always @(posedge clk) begin
      if (reset) begin
         m_pat = 0; m_len = 8; m_ovl = 1; q.delete(); ey = 0; ec8 = 0; ec2 = 0;
      end else begin
         hit = 0;
         if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
            m_ovl = cfg_overlap;
            q.delete();
         end else if (en) begin
            q.push_back(x);
            if (q.size() > 8) void'(q.pop_front());
            if (q.size() >= m_len) begin
               hit = 1;
               for (int i = 0; i < m_len; i++)
                  if (q[q.size()-1-i] != m_pat[i]) hit = 0;
            end
            if (hit && !m_ovl) q.delete();
         end
         ey  = hit;
         ec8 = cnt_clr ? int'(hit) : (hit && ec8 < 255) ? ec8 + 1 : ec8;
         ec2 = cnt_clr ? int'(hit) : (hit && ec2 < 3) ? ec2 + 1 : ec2;
      end
   end

   always @(negedge clk) if (run) begin
      check("y8", int'(y8), int'(ey));
      check("cnt8", int'(cnt8), ec8);
      check("y2", int'(y2), int'(ey));
      check("cnt2", int'(cnt2), ec2);
   end

   task automatic tick(input logic e, input logic xb);
      en = e; x = xb;
      @(posedge clk); #2;
      en = 0; x = 0; cfg_load = 0; cnt_clr = 0; reset = 0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1;
      tick(0, 0);
   endtask

   task automatic bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tick(1, v[i]);
   endtask

   initial begin
      reset = 1; tick(0, 0);
      run = 1;
      check("reset_y", int'(y8), 0);
      check("reset_cnt", int'(cnt8), 0);
      load(8'h0B, 4, 1);
      bits(3'b101, 3);
      reset = 1; tick(0, 0);
      load(8'h0B, 4, 1);
      tick(1, 1);
      check("after_reset_no_hit", int'(y8), 0);
      load(8'h0B, 4, 1);
      bits(4'b1011, 4);
      check("ovl_hit1", int'(y8), 1);
      bits(3'b011, 3);
      check("ovl_hit2", int'(y8), 1);
      check("ovl_cnt", int'(cnt8), 2);
      cnt_clr = 1; load(8'h0B, 4, 0);
      bits(4'b1011, 4);
      check("novl_hit", int'(y8), 1);
      bits(3'b011, 3);
      check("novl_no_hit7", int'(y8), 0);
      check("novl_cnt", int'(cnt8), 1);
      tick(1, 1);
      check("novl_no_hit8", int'(y8), 0);
      bits(4'b1011, 4);
      check("novl_fresh_hit", int'(y8), 1);
      load(8'h0B, 4, 1);
      bits(2'b10, 2);
      for (int i = 0; i < 3; i++) tick(0, 1);
      bits(2'b11, 2);
      check("gap_hit", int'(y8), 1);
      tick(0, 0);
      check("gap_single", int'(y8), 0);
      bits(3'b101, 3);
      cfg_pattern = 8'h0B; cfg_len = 4; cfg_overlap = 1; cfg_load = 1;
      tick(1, 1);
      check("load_collide", int'(y8), 0);
      tick(1, 1);
      check("load_cleared", int'(y8), 0);
      cnt_clr = 1; load(8'h01, 0, 0);
      bits(4'b1101, 4);
      check("len1_cnt", int'(cnt8), 3);
      check("len1_last", int'(y8), 1);
      load(8'hA5, 15, 1);
      bits(8'hA5 >> 1, 7);
      check("clamp_no_hit7", int'(y8), 0);
      tick(1, 1);
      check("clamp_hit8", int'(y8), 1);
      cnt_clr = 1; load(8'h01, 1, 1);
      bits(5'b11111, 5);
      check("sat_cnt2", int'(cnt2), 3);
      check("sat_cnt8", int'(cnt8), 5);
      cnt_clr = 1; tick(1, 1);
      check("clr_hit_cnt2", int'(cnt2), 1);
      check("clr_hit_cnt8", int'(cnt8), 1);
      tick(0, 0);
      @(negedge clk); #1;
      run = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
